// File: rtl/kalman_pkg.sv
// Shared definitions for the Kalman measurement path: default widths, the
// accumulator width derivation and the centroid FSM state encoding.
package kalman_pkg;

    localparam int DEF_DISP_WIDTH = 11;
    localparam int DEF_CNT_WIDTH  = 20;
    localparam int DEF_MIN_PIXELS = 16;

    // A sum of up to 2**cnt_w coordinates of disp_w bits never needs more than this.
    function automatic int sum_width(input int disp_w, input int cnt_w);
        return disp_w + cnt_w;
    endfunction

    localparam int DEF_SUM_WIDTH = sum_width(DEF_DISP_WIDTH, DEF_CNT_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_OUTPUT = 2'd2
    } meas_state_e;

endpackage

// File: rtl/centroid_meas_gen_if.sv
// Pixel stream in, centroid measurement out: the signals between the threshold
// stage, the centroid generator and the Kalman filter.
interface centroid_meas_gen_if
    import kalman_pkg::*;
#(
    parameter int DISP_WIDTH = DEF_DISP_WIDTH
);
    logic [DISP_WIDTH-1:0] pix_x;
    logic [DISP_WIDTH-1:0] pix_y;
    logic                  pix_valid;
    logic                  pix_match;
    logic                  frame_end;
    logic [DISP_WIDTH-1:0] z_x;
    logic [DISP_WIDTH-1:0] z_y;
    logic                  valid;
    logic                  ready;
    logic                  busy;
    logic                  frame_drop;

    // Pixel source and measurement consumer side.
    modport master (
        output pix_x, pix_y, pix_valid, pix_match, frame_end, ready,
        input  z_x, z_y, valid, busy, frame_drop
    );

    // Centroid generator side.
    modport slave (
        input  pix_x, pix_y, pix_valid, pix_match, frame_end, ready,
        output z_x, z_y, valid, busy, frame_drop
    );
endinterface

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle. Operands are latched
// on start_i; done_o pulses for one cycle when quotient_o holds the result.
module seq_divider #(
    parameter int WIDTH = 31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o
);
    localparam int CW = $clog2(WIDTH + 1);

    // quot_q starts as the dividend and fills with quotient bits from the right.
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH:0]   rem_shift;
    logic [CW-1:0]    count_q, count_d;
    logic             done_q, done_d;

    // NOTE: every variable gets a default at the top so no latch is inferred.
    always_comb begin
        quot_d    = quot_q;
        dvsr_d    = dvsr_q;
        rem_d     = rem_q;
        count_d   = count_q;
        done_d    = 1'b0;
        rem_shift = {rem_q, quot_q[WIDTH-1]};
        if (start_i) begin
            quot_d  = dividend_i;
            dvsr_d  = divisor_i;
            rem_d   = '0;
            count_d = CW'(WIDTH);
        end else if (count_q != '0) begin
            count_d = count_q - CW'(1);
            done_d  = (count_q == CW'(1));
            if (rem_shift >= {1'b0, dvsr_q}) begin
                rem_d  = WIDTH'(rem_shift - {1'b0, dvsr_q});
                quot_d = {quot_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d  = rem_shift[WIDTH-1:0];
                quot_d = {quot_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            quot_q  <= '0;
            dvsr_q  <= '0;
            rem_q   <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            quot_q  <= quot_d;
            dvsr_q  <= dvsr_d;
            rem_q   <= rem_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign done_o     = done_q;
    assign quotient_o = quot_q;

endmodule

// File: rtl/centroid_meas_gen.sv
// Accumulates matched-pixel coordinates over a frame and divides by the pixel
// count to present a (z_x, z_y) centroid measurement to the Kalman filter.
module centroid_meas_gen
    import kalman_pkg::*;
#(
    parameter int DISP_WIDTH = DEF_DISP_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
    parameter int MIN_PIXELS = DEF_MIN_PIXELS
) (
    input  logic               clk,
    input  logic               reset,
    centroid_meas_gen_if.slave meas_io
);
    localparam int SUM_WIDTH = sum_width(DISP_WIDTH, CNT_WIDTH);
    localparam logic [CNT_WIDTH-1:0] MIN_CNT = CNT_WIDTH'(MIN_PIXELS);

    logic                  pix_hit;
    logic [SUM_WIDTH-1:0]  sum_x_q, sum_x_d, sum_y_q, sum_y_d;
    logic [SUM_WIDTH-1:0]  fin_sum_x, fin_sum_y;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d, fin_cnt;
    logic                  ovf_q, ovf_d, fin_ovf;
    logic                  frame_ok;

    meas_state_e           state_q, state_d;
    logic [DISP_WIDTH-1:0] z_x_q, z_x_d, z_y_q, z_y_d;
    logic                  frame_drop_q, frame_drop_d;
    logic                  start_div, meas_valid, meas_busy;
    logic                  done_x, done_y, div_done;
    logic [SUM_WIDTH-1:0]  quot_x, quot_y;

    assign pix_hit = meas_io.pix_valid & meas_io.pix_match;

    // fin_* include the pixel of the current cycle, so a pixel on frame_end
    // still lands in the frame it ends.
    always_comb begin
        fin_sum_x = sum_x_q;
        fin_sum_y = sum_y_q;
        fin_cnt   = cnt_q;
        fin_ovf   = ovf_q;
        if (pix_hit) begin
            fin_sum_x = sum_x_q + SUM_WIDTH'(meas_io.pix_x);
            fin_sum_y = sum_y_q + SUM_WIDTH'(meas_io.pix_y);
            if (&cnt_q) fin_ovf = 1'b1;
            else        fin_cnt = cnt_q + CNT_WIDTH'(1);
        end
        if (meas_io.frame_end) begin
            sum_x_d = '0;
            sum_y_d = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            sum_x_d = fin_sum_x;
            sum_y_d = fin_sum_y;
            cnt_d   = fin_cnt;
            ovf_d   = fin_ovf;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_x_q <= '0;
            sum_y_q <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            sum_x_q <= sum_x_d;
            sum_y_q <= sum_y_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign frame_ok = meas_io.frame_end && (fin_cnt >= MIN_CNT) && !fin_ovf;
    assign div_done = done_x & done_y;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            z_x_q        <= '0;
            z_y_q        <= '0;
            frame_drop_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            z_x_q        <= z_x_d;
            z_y_q        <= z_y_d;
            frame_drop_q <= frame_drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (frame_ok)      state_d = ST_DIVIDE;
            ST_DIVIDE: if (div_done)      state_d = ST_OUTPUT;
            ST_OUTPUT: if (meas_io.ready) state_d = ST_IDLE;
            default:                      state_d = ST_IDLE;
        endcase
    end

    // A frame ending while a measurement is still in flight is thrown away.
    always_comb begin
        start_div    = 1'b0;
        meas_valid   = 1'b0;
        meas_busy    = 1'b1;
        z_x_d        = z_x_q;
        z_y_d        = z_y_q;
        frame_drop_d = meas_io.frame_end && (state_q != ST_IDLE);
        unique case (state_q)
            ST_IDLE: begin
                meas_busy = 1'b0;
                start_div = frame_ok;
            end
            ST_DIVIDE: begin
                if (div_done) begin
                    z_x_d = quot_x[DISP_WIDTH-1:0];
                    z_y_d = quot_y[DISP_WIDTH-1:0];
                end
            end
            ST_OUTPUT: meas_valid = 1'b1;
            default:   meas_busy  = 1'b0;
        endcase
    end

    seq_divider #(.WIDTH(SUM_WIDTH)) u_div_x (
        .clk        (clk),
        .reset      (reset),
        .start_i    (start_div),
        .dividend_i (fin_sum_x),
        .divisor_i  (SUM_WIDTH'(fin_cnt)),
        .done_o     (done_x),
        .quotient_o (quot_x)
    );

    seq_divider #(.WIDTH(SUM_WIDTH)) u_div_y (
        .clk        (clk),
        .reset      (reset),
        .start_i    (start_div),
        .dividend_i (fin_sum_y),
        .divisor_i  (SUM_WIDTH'(fin_cnt)),
        .done_o     (done_y),
        .quotient_o (quot_y)
    );

    // A mean of coordinates can never exceed the largest coordinate.
    assert property (@(posedge clk) disable iff (reset)
        (state_q == ST_DIVIDE && div_done) |->
            (quot_x[SUM_WIDTH-1:DISP_WIDTH] == '0 && quot_y[SUM_WIDTH-1:DISP_WIDTH] == '0));

    assign meas_io.z_x        = z_x_q;
    assign meas_io.z_y        = z_y_q;
    assign meas_io.valid      = meas_valid;
    assign meas_io.busy       = meas_busy;
    assign meas_io.frame_drop = frame_drop_q;

endmodule

// File: doc/centroid_meas_gen.md
Name: centroid_meas_gen

Overview:
- Producer end of the Kalman filter's measurement interface.
- Accumulates coordinates of colour-matched pixels across one video frame, then divides the sums by the pixel count to get the centroid.
- Presents the centroid as (z_x, z_y) on a valid/ready handshake, held stable until accepted.
- Sits between the pixel-threshold stage and the Kalman filter.

Parameters:
- DISP_WIDTH, 11: coordinate width; must match the Kalman filter's DISP_WIDTH.
- CNT_WIDTH, 20: matched-pixel counter width.
- MIN_PIXELS, 16: minimum matched pixels for a frame to produce a measurement.
- SUM_WIDTH (localparam) = DISP_WIDTH+CNT_WIDTH = 31: accumulator and divider width.

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- pix_x  in  DISP_WIDTH  pixel column
- pix_y  in  DISP_WIDTH  pixel row
- pix_valid  in  1  pixel qualifier
- pix_match  in  1  pixel passed colour threshold
- frame_end  in  1  one-cycle pulse on the last pixel of a frame
- z_x  out  DISP_WIDTH  centroid x
- z_y  out  DISP_WIDTH  centroid y
- valid  out  1  measurement available
- ready  in  1  consumer accepts
- busy  out  1  state != IDLE
- frame_drop  out  1  one-cycle pulse: a completed frame was discarded because the block was busy

Behaviour:
- Reset (sampled on the clk edge):
  - state=IDLE; z_x=z_y=0; valid=0; busy=0; frame_drop=0.
  - Accumulators and counter cleared; divider idle.
  - Reset mid-divide or mid-handshake abandons the result.
- Accumulation:
  - Runs in every state.
  - Each cycle with pix_valid&pix_match: sum_x+=pix_x, sum_y+=pix_y, cnt+=1.
  - A pixel coincident with frame_end belongs to the ending frame.
- Counter overflow:
  - cnt saturates at all-ones and sets a sticky ovf flag.
  - A frame with ovf set is discarded at frame_end, with no output.
- Frame boundary:
  - On the cycle after frame_end, accumulators, cnt and ovf restart from zero.
  - A matched pixel on that next cycle is counted into the new frame.
- State machine IDLE / DIVIDE / OUTPUT:
  - IDLE, frame_end, final cnt>=MIN_PIXELS and !ovf: latch final sums and cnt into both dividers; go to DIVIDE.
  - IDLE, frame_end otherwise: stay in IDLE; no output, no frame_drop.
  - DIVIDE or OUTPUT, frame_end: frame discarded; frame_drop pulses the following cycle; state unaffected.
  - DIVIDE: both dividers run in parallel for SUM_WIDTH cycles. On completion, z_x/z_y load the quotients, valid=1, go to OUTPUT.
  - OUTPUT: valid held high and z_x/z_y stable until valid&ready is sampled. Then valid=0 next cycle and state returns to IDLE.
- Latency:
  - frame_end high in cycle k gives valid high in cycle k+SUM_WIDTH+2 (k+33 at defaults).
  - The earliest accepted next frame_end is the cycle after the handshake.
- Handshake:
  - valid never depends combinationally on ready.
  - ready while valid=0 is ignored.
  - z_x/z_y retain the last measurement after the handshake and until the next load.
- Arithmetic:
  - Unsigned restoring division, one quotient bit per cycle; floor rounding.
  - Quotient is <= max coordinate by construction; the low DISP_WIDTH bits are taken; upper bits are asserted zero in simulation.

Decomposition:
- Shared package kalman_pkg:
  - state encoding (IDLE/DIVIDE/OUTPUT)
  - DISP_WIDTH default
  - SUM_WIDTH derivation
- Natural sub-module seq_divider, instantiated twice (x and y):
  - parameterised width
  - start/done handshake
  - dividend/divisor latched on start
  - quotient register

Test Plan:
- Single frame: 16 matched pixels, x=100..103 × y=50..53, frame_end in cycle k -> valid at k+33; z_x=101 (1624/16), z_y=51 (824/16).
- Threshold and mask: 15 matched pixels plus pixel (2047,0) with pix_match=0 -> no valid, frame_drop=0, z outputs keep previous values.
- Backpressure: ready low 100 cycles after valid -> valid and z stable throughout; ready high one cycle -> valid=0 next cycle, busy=0.
- Busy drop: second frame_end 10 cycles into DIVIDE -> frame_drop pulses once; first result correct; following frame (x=10, y=20, 20 pixels) yields z=(10,20).
- Boundary pixel: matched pixel (200,200) on the frame_end cycle with 16 others at (0,0) -> z_x=z_y=11 (200/17 floor); next-frame accumulators exclude it.
- Reset mid-DIVIDE: reset high one cycle -> valid=0, z=0, busy=0 next cycle; subsequent 16-pixel frame at (5,5) -> z=(5,5) at k+33.
